// File: rtl/wb_burst_slave.sv
// wb_burst_slave: Wishbone B4 registered-feedback slave with a DEPTH-word
// byte-laned register file. Serves classic, constant-address and
// incrementing bursts, answers tagged reads with the ack counter and
// terminates illegal accesses with err_o.
module wb_burst_slave #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH       = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [2:0]            cti_i,
    input  logic                  tga_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [15:0]           acc_cnt
);

    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [2:0]          WS_L      = 3'(WAIT_STATES);
    localparam logic [2:0]          CTI_CONST = 3'b001;
    localparam logic [2:0]          CTI_INC   = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   bp_q, bp_d;
    logic [ADDR_WIDTH-1:0]   beat_adr;
    logic [2:0]              wcnt_q, wcnt_d;
    logic                    burst_q, burst_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [IDX_W-1:0]        idx;
    logic                    fire;
    logic                    in_range;
    logic                    cti_rsvd;
    logic                    beat_err;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // A beat "fires" on the edge where its ack/err is registered, so the
    // response is visible in the following cycle. S_BEAT is the cycle in
    // which that response is on the bus; burst_q records whether the acked
    // beat keeps the burst open so the next beat can fire straight away.
    always_comb begin
        state_d  = state_q;
        bp_d     = bp_q;
        wcnt_d   = wcnt_q;
        burst_d  = burst_q;
        fire     = 1'b0;
        beat_adr = bp_q;
        if (!cyc_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stb_i) begin
                        bp_d     = adr_i;
                        beat_adr = adr_i;
                        if (WS_L == 3'd0) begin
                            fire = 1'b1;
                        end else begin
                            wcnt_d  = WS_L;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (stb_i) begin
                        if (wcnt_q == 3'd1) fire = 1'b1;
                        else                wcnt_d = wcnt_q - 3'd1;
                    end
                end
                S_BEAT: begin
                    if (!burst_q)   state_d = S_IDLE;
                    else if (stb_i) fire = 1'b1;
                    else            state_d = S_BURST;
                end
                S_BURST: begin
                    if (stb_i) fire = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        in_range = ({1'b0, beat_adr} < DEPTH_L);
        cti_rsvd = (cti_i == 3'b011) || (cti_i == 3'b100) ||
                   (cti_i == 3'b101) || (cti_i == 3'b110);
        beat_err = !in_range || cti_rsvd || (we_i && tga_i);
        ack_d    = fire && !beat_err;
        err_d    = fire && beat_err;

        if (fire) begin
            state_d = S_BEAT;
            burst_d = !beat_err && ((cti_i == CTI_CONST) || (cti_i == CTI_INC));
            if (!beat_err && (cti_i == CTI_INC)) bp_d = beat_adr + ADDR_WIDTH'(1);
        end
    end

    // Read data selection and ack counter for the firing beat.
    always_comb begin
        idx     = beat_adr[IDX_W-1:0];
        rd_word = in_range ? mem_q[idx] : '0;
        dat_d   = '0;
        if (ack_d && !we_i) dat_d = tga_i ? DATA_WIDTH'(cnt_q) : rd_word;
        cnt_d   = ack_d ? cnt_q + 16'd1 : cnt_q;
    end

    // Control state, burst pointer and registered bus responses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            bp_q    <= '0;
            wcnt_q  <= '0;
            burst_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bp_q    <= bp_d;
            wcnt_q  <= wcnt_d;
            burst_q <= burst_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register file: cleared on reset, byte-laned writes on acked beats only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (ack_d && we_i) begin
            for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
                if (sel_i[b]) mem_q[idx][8*b +: 8] <= dat_i[8*b +: 8];
            end
        end
    end

    assign ack_o   = ack_q & cyc_i;
    assign err_o   = err_q & cyc_i;
    assign dat_o   = dat_q;
    assign acc_cnt = cnt_q;

endmodule

// File: doc/wb_burst_slave.md
# wb_burst_slave

Wishbone B4 registered-feedback slave responding to the multi-slave master's strobes. One instance sits on each `stb` lane of the master. It holds a DEPTH-word byte-laned register file and serves classic, constant-address burst and incrementing burst cycles. It answers tagged reads (`tga_i`) with an access counter, and flags illegal accesses with `err_o`.

## Interface
- `ADDR_WIDTH`, 4: word address width.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `SEL_WIDTH`, DATA_WIDTH/8: byte-select width.
- `DEPTH`, 12: implemented words. Addresses DEPTH..2^ADDR_WIDTH-1 are illegal.
- `WAIT_STATES`, 0: extra cycles before the first ack of each cycle. Legal range 0..7.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: this slave's strobe, which is one bit of the master's `stb_o`.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in ADDR_WIDTH: word address.
- `dat_i` in DATA_WIDTH: write data.
- `sel_i` in SEL_WIDTH: byte enables.
- `cti_i` in 3: cycle type. 000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst, others reserved.
- `tga_i` in 1: address tag. 1 on a read selects the access counter.
- `dat_o` out DATA_WIDTH: read data, valid while `ack_o`=1.
- `ack_o` out 1: normal termination.
- `err_o` out 1: error termination.
- `acc_cnt` out 16: number of acks since reset (debug).

## Operation
States: IDLE, WAIT, BEAT, BURST.
- **IDLE**
  - Enter on `cyc_i & stb_i`.
  - Latch `adr_i` into the burst pointer `bp`.
  - Go to WAIT if WAIT_STATES>0, else BEAT.
- **WAIT**
  - Count down WAIT_STATES cycles, then go to BEAT.
  - If `stb_i` drops, hold the count.
- **BEAT**
  - Qualify the access and drive exactly one of `ack_o` or `err_o` for one cycle.
  - Error when any of these holds: `bp`≥DEPTH; reserved `cti_i` (011..110); write with `tga_i`=1. On error go to IDLE.
  - Otherwise ack. On `cti_i`=001 or 010, go to BURST; else go to IDLE.
- **BURST**
  - Each cycle with `stb_i`=1: ack one beat. No wait states after the first beat.
  - On 010, `bp` increments after each beat, wrapping modulo 2^ADDR_WIDTH (linear only).
  - On 001, `bp` is held.
  - A beat whose `bp` reaches ≥DEPTH gets `err_o` instead, then IDLE.
  - The beat presented with `cti_i`=111 is the last beat; then IDLE.
  - `stb_i`=0 is a master wait: no ack, `bp` frozen, stay in BURST.
- Writes on an acked beat update the selected bytes of `mem[bp]` only. Errored beats never write.
- Reads: `dat_o` = `mem[bp]`, or `acc_cnt` zero-extended when `tga_i`=1.
- `acc_cnt` increments on each `ack_o`, wraps at 0xFFFF. `err_o` does not count. A tagged read returns the count value from before its own ack.
- `cyc_i` falling in any state goes to IDLE next edge, with no ack/err for the pending beat.

## Timing
- Reset (`rst_i`=0, async):
  - state IDLE.
  - `ack_o`=0, `err_o`=0, `dat_o`=0, `acc_cnt`=0, `bp`=0.
  - mem cleared to 0.
  - Release is synchronous to the next rising edge.
- `ack_o`, `err_o` and `dat_o` are registered. They are never both 1 and never asserted while `cyc_i`=0.
- First-beat latency:
  - With `stb_i` sampled high at edge E, the ack/err is high in the cycle after edge E+WAIT_STATES.
  - WAIT_STATES=0 gives a 1-cycle latency.
- Burst throughput: one beat per cycle after the first while `stb_i` is held. A burst of N beats takes N+WAIT_STATES+1 cycles.
- Classic: the ack is high for exactly one cycle. If `stb_i` is still high in the cycle after the ack, it is a new access.
- Reset mid-burst: outputs clear immediately, and the partial burst is not resumed.
- The beat's `sel_i` and `dat_i` are sampled on the edge where `ack_o` is being asserted for that beat.

## Test plan
- **Classic write/readback.** Write 0x0000_1111 to addr 0 and 0x0000_2222 to addr 1, `sel`=F, `cti`=000. Read both back: one ack per access, data match, `acc_cnt`=4.
- **Incrementing burst.** Write from addr 3 with 4 beats 0xA0..0xA3, the last with `cti`=111. Expect acks in 4 consecutive cycles. A `cti`=010 read from 3 then returns the same 4 words.
- **Constant burst and master wait.** `cti`=001 write of 3 beats to addr 5, with `stb_i` dropped 2 cycles mid-burst. Expect no ack during the gap. A read of addr 5 returns the third beat's data.
- **Errors.**
  - Classic write to addr 9 with DEPTH=8: `err_o` pulses once and mem is unchanged.
  - Incrementing burst from addr 7: beat 2 errs.
  - `cti`=011: `err_o`.
  - Tagged write: `err_o`.
- **Tag read and byte lanes.** After 5 acks, a tagged read at addr 2 returns 5. A `sel`=0011 write of 0xFFFF_FFFF over 0x1111_0000 reads back 0x1111_FFFF.
- **Abort and reset.**
  - Drop `cyc_i` on burst beat 2: no further acks, state IDLE.
  - Assert `rst_i`=0 mid-burst: outputs 0 within the same cycle, and mem reads 0 afterwards.
